mdio_slave: RTL and testbench

Clause-22 MDIO responder (PHY side) with a 32 x 16 register file. It decodes management frames arriving on MDC/MDIO and answers reads by driving MDIO. It commits writes to the register file and reports each one to local logic. Two uses in the design: the loopback target for `mdio_cfg` in board self-test, and the management front end of FPGA-emulated PHY functions. It runs on one system clock and oversamples MDC.

---
 rtl/mdio_pkg.sv | 27 ++
 rtl/mdio_edge_sync.sv | 39 +++
 rtl/mdio_slave.sv | 258 +++++++++++++++++++++++++
 tb/tb_mdio_slave.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared constants, FSM state type and helpers for the MDIO responder
package mdio_pkg;

  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 16;
  localparam int PREAMBLE_LEN = 32;

  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_RD_DATA,
    S_WR_DATA
  } mdio_state_e;

  // Registers 2 and 3 hold the PHY identifier and never accept writes
  function automatic logic is_ro_addr(input logic [ADDR_W-1:0] a);
    return (a == 5'd2) || (a == 5'd3);
  endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// rtl/mdio_edge_sync.sv - MDC/MDIO synchronizers and registered MDC edge strobes
module mdio_edge_sync (
  input  logic clk,
  input  logic resetn,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic mdio_s_o,
  output logic mdc_rise_o,
  output logic mdc_fall_o
);

  logic [1:0] mdc_sync_q;
  logic [1:0] mdio_sync_q;
  logic       mdc_prev_q;
  logic       rise_q;
  logic       fall_q;

  // Two-stage synchronizers, then one register of edge detection on synced MDC
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '0;
      mdc_prev_q  <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[0], mdc_i};
      mdio_sync_q <= {mdio_sync_q[0], mdio_i};
      mdc_prev_q  <= mdc_sync_q[1];
      rise_q      <= mdc_sync_q[1] & ~mdc_prev_q;
      fall_q      <= ~mdc_sync_q[1] & mdc_prev_q;
    end
  end

  assign mdio_s_o   = mdio_sync_q[1];
  assign mdc_rise_o = rise_q;
  assign mdc_fall_o = fall_q;

endmodule

// File: rtl/mdio_slave.sv
// rtl/mdio_slave.sv - Clause-22 MDIO responder with a 32 x 16 register file and local port
module mdio_slave
  import mdio_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PHY_ADDR = 5'd0,
  parameter logic [DATA_W-1:0] PHY_ID1  = 16'h0000,
  parameter logic [DATA_W-1:0] PHY_ID2  = 16'h0000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mdc,
  input  logic              mdio_i,
  output logic              mdio_o,
  output logic              mdio_oe,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_wdata,
  output logic [DATA_W-1:0] loc_rdata,
  output logic              wr_evt,
  output logic [ADDR_W-1:0] wr_evt_addr,
  output logic [DATA_W-1:0] wr_evt_data,
  output logic              frame_err
);

  localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_LEN);

  logic mdio_s;
  logic mdc_rise;
  logic mdc_fall;

  mdio_edge_sync u_sync (
    .clk        (clk),
    .resetn     (resetn),
    .mdc_i      (mdc),
    .mdio_i     (mdio_i),
    .mdio_s_o   (mdio_s),
    .mdc_rise_o (mdc_rise),
    .mdc_fall_o (mdc_fall)
  );

  mdio_state_e       state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [5:0]        pre_q, pre_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sh_q, sh_d;

  logic              oe_q, oe_d;
  logic              o_q, o_d;
  logic              wr_evt_q, wr_evt_d;
  logic              ferr_q, ferr_d;
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic [DATA_W-1:0] ed_q, ed_d;
  logic [DATA_W-1:0] loc_rdata_q;

  logic [DATA_W-1:0] regs_q [32];

  logic [1:0] op_next;
  assign op_next = {op_q[0], mdio_s};

  // FSM and frame datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      sh_q    <= sh_d;
    end
  end

  // Next-state: one frame bit per mdc_rise; read data shifts out on mdc_fall
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    op_d    = op_q;
    addr_d  = addr_q;
    sh_d    = sh_q;
    if (mdc_rise) begin
      unique case (state_q)
        S_IDLE: begin
          if (mdio_s) begin
            if (pre_q != PRE_MAX) pre_d = pre_q + 6'd1;
          end else begin
            if (pre_q == PRE_MAX) state_d = S_ST;
            pre_d = '0;
          end
        end
        S_ST: begin
          cnt_d   = '0;
          state_d = mdio_s ? S_OP : S_IDLE;
        end
        S_OP: begin
          op_d = op_next;
          if (cnt_q == 5'd0) begin
            cnt_d = 5'd1;
          end else begin
            cnt_d   = '0;
            state_d = (op_next == MDIO_OP_RD || op_next == MDIO_OP_WR) ? S_PHYAD : S_IDLE;
          end
        end
        S_PHYAD: begin
          addr_d = {addr_q[ADDR_W-2:0], mdio_s};
          if (cnt_q == 5'd4) begin
            cnt_d = '0;
            if (addr_d == PHY_ADDR) begin
              state_d = S_REGAD;
            end else begin
              state_d = S_IDLE;
              pre_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_REGAD: begin
          addr_d = {addr_q[ADDR_W-2:0], mdio_s};
          if (cnt_q == 5'd4) begin
            cnt_d   = '0;
            state_d = S_TA;
            // Snapshot uses the registered array, so a same-cycle commit is not visible
            if (op_q == MDIO_OP_RD) sh_d = regs_q[addr_d];
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_TA: begin
          if (op_q == MDIO_OP_RD) begin
            if (cnt_q == 5'd0) begin
              cnt_d = 5'd1;
            end else begin
              cnt_d   = '0;
              state_d = S_RD_DATA;
            end
          end else if (cnt_q == 5'd0) begin
            if (mdio_s) cnt_d = 5'd1;
            else        state_d = S_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = mdio_s ? S_IDLE : S_WR_DATA;
          end
        end
        S_RD_DATA: cnt_d = cnt_q + 5'd1;
        S_WR_DATA: begin
          sh_d = {sh_q[DATA_W-2:0], mdio_s};
          if (cnt_q == 5'd15) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (mdc_fall && state_q == S_RD_DATA) begin
      if (cnt_q == 5'd16) begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end else begin
        sh_d = {sh_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Output decode: pad drive on mdc_fall, write commit and error pulses on mdc_rise
  always_comb begin
    oe_d     = oe_q;
    o_d      = o_q;
    wr_evt_d = 1'b0;
    ferr_d   = 1'b0;
    ea_d     = ea_q;
    ed_d     = ed_q;
    if (mdc_fall) begin
      if (state_q == S_TA && op_q == MDIO_OP_RD && cnt_q == 5'd1) begin
        oe_d = 1'b1;
        o_d  = 1'b0;
      end else if (state_q == S_RD_DATA) begin
        if (cnt_q == 5'd16) begin
          oe_d = 1'b0;
          o_d  = 1'b0;
        end else begin
          o_d = sh_q[DATA_W-1];
        end
      end
    end
    if (mdc_rise) begin
      if (state_q == S_OP && cnt_q == 5'd1 &&
          op_next != MDIO_OP_RD && op_next != MDIO_OP_WR) begin
        ferr_d = 1'b1;
      end
      if (state_q == S_TA && op_q != MDIO_OP_RD &&
          ((cnt_q == 5'd0 && !mdio_s) || (cnt_q == 5'd1 && mdio_s))) begin
        ferr_d = 1'b1;
      end
      if (state_q == S_WR_DATA && cnt_q == 5'd15) begin
        wr_evt_d = 1'b1;
        ea_d     = addr_q;
        ed_d     = {sh_q[DATA_W-2:0], mdio_s};
      end
    end
  end

  // Registered pad drive and event outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oe_q     <= 1'b0;
      o_q      <= 1'b0;
      wr_evt_q <= 1'b0;
      ferr_q   <= 1'b0;
      ea_q     <= '0;
      ed_q     <= '0;
    end else begin
      oe_q     <= oe_d;
      o_q      <= o_d;
      wr_evt_q <= wr_evt_d;
      ferr_q   <= ferr_d;
      ea_q     <= ea_d;
      ed_q     <= ed_d;
    end
  end

  // Register file: MDIO commit takes priority over a local write to the same address
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      regs_q[2] <= PHY_ID1;
      regs_q[3] <= PHY_ID2;
    end else begin
      if (wr_evt_d && !is_ro_addr(ea_d)) regs_q[ea_d] <= ed_d;
      if (loc_we && !is_ro_addr(loc_addr) && !(wr_evt_d && ea_d == loc_addr))
        regs_q[loc_addr] <= loc_wdata;
    end
  end

  // Registered local read port
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) loc_rdata_q <= '0;
    else         loc_rdata_q <= regs_q[loc_addr];
  end

  assign mdio_o      = o_q;
  assign mdio_oe     = oe_q;
  assign wr_evt      = wr_evt_q;
  assign wr_evt_addr = ea_q;
  assign wr_evt_data = ed_q;
  assign frame_err   = ferr_q;
  assign loc_rdata   = loc_rdata_q;

endmodule

// File: tb/tb_mdio_slave.sv
// tb/tb_mdio_slave.sv - directed self-checking bench for mdio_slave
module tb_mdio_slave;

  localparam logic [4:0]  PA  = 5'd5;
  localparam logic [15:0] ID1 = 16'hBEEF;
  localparam logic [15:0] ID2 = 16'h1234;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mdc = 1'b0;
  logic        mdio_o, mdio_oe;
  logic        loc_we = 1'b0;
  logic [4:0]  loc_addr = '0;
  logic [15:0] loc_wdata = '0;
  logic [15:0] loc_rdata;
  logic        wr_evt;
  logic [4:0]  wr_evt_addr;
  logic [15:0] wr_evt_data;
  logic        frame_err;

  logic m_oe = 1'b0;
  logic m_val = 1'b1;
  logic pad;
  assign pad = mdio_oe ? mdio_o : (m_oe ? m_val : 1'b1);

  mdio_slave #(.PHY_ADDR(PA), .PHY_ID1(ID1), .PHY_ID2(ID2)) dut (
    .clk(clk), .resetn(resetn), .mdc(mdc), .mdio_i(pad), .mdio_o(mdio_o), .mdio_oe(mdio_oe),
    .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
    .wr_evt(wr_evt), .wr_evt_addr(wr_evt_addr), .wr_evt_data(wr_evt_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int          evt_cnt = 0;
  int          ferr_cnt = 0;
  int          both_cnt = 0;
  logic [4:0]  evt_addr_s = '0;
  logic [15:0] evt_data_s = '0;

  always @(negedge clk) begin
    if (wr_evt === 1'b1) begin
      evt_cnt++;
      evt_addr_s = wr_evt_addr;
      evt_data_s = wr_evt_data;
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if (wr_evt === 1'b1 && frame_err === 1'b1) both_cnt++;
  end

  logic        samp, samp_oe, ta1_oe, post_oe;
  logic [1:0]  rd_ta;
  logic [15:0] rd_data;
  int          oe_hits;
  int          e0, f0;

  task automatic bit_cyc(input logic drv, input logic v);
    m_oe = drv;
    m_val = v;
    repeat (5) @(negedge clk);
    samp = pad;
    samp_oe = mdio_oe;
    mdc = 1'b1;
    repeat (5) @(negedge clk);
    mdc = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bit_cyc(1'b1, v[i]);
  endtask

  task automatic header(input int npre, input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra);
    for (int i = 0; i < npre; i++) bit_cyc(1'b1, 1'b1);
    send({18'b0, 2'b01, op, pa, ra}, 14);
  endtask

  task automatic do_read(input int npre, input logic [4:0] pa, input logic [4:0] ra);
    header(npre, 2'b10, pa, ra);
    oe_hits = 0;
    rd_data = '0;
    bit_cyc(1'b0, 1'b0);
    rd_ta[1] = samp;
    ta1_oe = samp_oe;
    bit_cyc(1'b0, 1'b0);
    rd_ta[0] = samp;
    oe_hits += int'(samp_oe);
    for (int i = 0; i < 16; i++) begin
      bit_cyc(1'b0, 1'b0);
      rd_data = {rd_data[14:0], samp};
      oe_hits += int'(samp_oe);
    end
    repeat (6) @(negedge clk);
    post_oe = mdio_oe;
  endtask

  task automatic do_write(input int npre, input logic [1:0] op, input logic [4:0] pa,
                          input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] wd);
    header(npre, op, pa, ra);
    send({14'b0, ta, wd}, 18);
    m_oe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic loc_read(input logic [4:0] a);
    loc_addr = a;
    @(negedge clk);
  endtask

  task automatic loc_write(input logic [4:0] a, input logic [15:0] d);
    loc_addr = a;
    loc_wdata = d;
    loc_we = 1'b1;
    @(negedge clk);
    loc_we = 1'b0;
  endtask

  task automatic test_reset;
    loc_addr = 5'd2;
    repeat (4) @(negedge clk);
    total++; if (mdio_oe !== 1'b0) begin bad++; $display("FAIL rst_oe got=%b exp=0", mdio_oe); end
    total++; if (mdio_o !== 1'b0) begin bad++; $display("FAIL rst_o got=%b exp=0", mdio_o); end
    total++; if (wr_evt !== 1'b0) begin bad++; $display("FAIL rst_wr_evt got=%b exp=0", wr_evt); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_frame_err got=%b exp=0", frame_err); end
    total++; if (wr_evt_addr !== 5'd0) begin bad++; $display("FAIL rst_evt_addr got=%h exp=0", wr_evt_addr); end
    total++; if (wr_evt_data !== 16'h0) begin bad++; $display("FAIL rst_evt_data got=%h exp=0", wr_evt_data); end
    total++; if (loc_rdata !== 16'h0) begin bad++; $display("FAIL rst_loc_rdata got=%h exp=0", loc_rdata); end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    loc_read(5'd2);
    total++; if (loc_rdata !== ID1) begin bad++; $display("FAIL reg2_id1 got=%h exp=%h", loc_rdata, ID1); end
    loc_read(5'd3);
    total++; if (loc_rdata !== ID2) begin bad++; $display("FAIL reg3_id2 got=%h exp=%h", loc_rdata, ID2); end
    loc_read(5'd0);
    total++; if (loc_rdata !== 16'h0) begin bad++; $display("FAIL reg0_zero got=%h exp=0", loc_rdata); end
  endtask

  task automatic test_read_id;
    e0 = evt_cnt;
    do_read(32, PA, 5'd3);
    total++; if (rd_ta !== 2'b10) begin bad++; $display("FAIL rd_ta got=%b exp=10", rd_ta); end
    total++; if (ta1_oe !== 1'b0) begin bad++; $display("FAIL rd_ta1_oe got=%b exp=0", ta1_oe); end
    total++; if (oe_hits != 17) begin bad++; $display("FAIL rd_oe_bits got=%0d exp=17", oe_hits); end
    total++; if (rd_data !== ID2) begin bad++; $display("FAIL rd_id2 got=%h exp=%h", rd_data, ID2); end
    total++; if (post_oe !== 1'b0) begin bad++; $display("FAIL rd_release got=%b exp=0", post_oe); end
    total++; if (evt_cnt != e0) begin bad++; $display("FAIL rd_no_evt got=%0d exp=0", evt_cnt - e0); end
  endtask

  task automatic test_write;
    e0 = evt_cnt;
    f0 = ferr_cnt;
    do_write(32, 2'b01, PA, 5'd7, 2'b10, 16'hA5C3);
    total++; if (evt_cnt - e0 != 1) begin bad++; $display("FAIL wr_evt_count got=%0d exp=1", evt_cnt - e0); end
    total++; if (evt_addr_s !== 5'd7) begin bad++; $display("FAIL wr_evt_addr got=%h exp=07", evt_addr_s); end
    total++; if (evt_data_s !== 16'hA5C3) begin bad++; $display("FAIL wr_evt_data got=%h exp=a5c3", evt_data_s); end
    total++; if (ferr_cnt != f0) begin bad++; $display("FAIL wr_no_err got=%0d exp=0", ferr_cnt - f0); end
    loc_read(5'd7);
    total++; if (loc_rdata !== 16'hA5C3) begin bad++; $display("FAIL wr_loc_readback got=%h exp=a5c3", loc_rdata); end
    do_read(32, PA, 5'd7);
    total++; if (rd_data !== 16'hA5C3) begin bad++; $display("FAIL wr_mdio_readback got=%h exp=a5c3", rd_data); end
  endtask

  task automatic test_local;
    loc_write(5'd9, 16'h1357);
    loc_read(5'd9);
    total++; if (loc_rdata !== 16'h1357) begin bad++; $display("FAIL loc_wr9 got=%h exp=1357", loc_rdata); end
    loc_write(5'd2, 16'hFFFF);
    loc_read(5'd2);
    total++; if (loc_rdata !== ID1) begin bad++; $display("FAIL loc_ro2 got=%h exp=%h", loc_rdata, ID1); end
    do_read(32, PA, 5'd9);
    total++; if (rd_data !== 16'h1357) begin bad++; $display("FAIL loc_mdio_rd9 got=%h exp=1357", rd_data); end
    e0 = evt_cnt;
    do_write(32, 2'b01, PA, 5'd3, 2'b10, 16'h0000);
    total++; if (evt_cnt - e0 != 1) begin bad++; $display("FAIL ro3_evt got=%0d exp=1", evt_cnt - e0); end
    loc_read(5'd3);
    total++; if (loc_rdata !== ID2) begin bad++; $display("FAIL ro3_kept got=%h exp=%h", loc_rdata, ID2); end
  endtask

  task automatic test_bad_phyad;
    e0 = evt_cnt;
    f0 = ferr_cnt;
    do_write(32, 2'b01, 5'd6, 5'd7, 2'b10, 16'h0000);
    total++; if (evt_cnt != e0) begin bad++; $display("FAIL phy_no_evt got=%0d exp=0", evt_cnt - e0); end
    total++; if (ferr_cnt != f0) begin bad++; $display("FAIL phy_no_err got=%0d exp=0", ferr_cnt - f0); end
    loc_read(5'd7);
    total++; if (loc_rdata !== 16'hA5C3) begin bad++; $display("FAIL phy_reg_kept got=%h exp=a5c3", loc_rdata); end
    do_read(32, 5'd6, 5'd3);
    total++; if (oe_hits != 0) begin bad++; $display("FAIL phy_no_drive got=%0d exp=0", oe_hits); end
  endtask

  task automatic test_frame_err;
    e0 = evt_cnt;
    f0 = ferr_cnt;
    do_write(32, 2'b01, PA, 5'd7, 2'b11, 16'hFFFF);
    total++; if (ferr_cnt - f0 != 1) begin bad++; $display("FAIL ta11_err got=%0d exp=1", ferr_cnt - f0); end
    do_write(32, 2'b11, PA, 5'd7, 2'b10, 16'h0000);
    total++; if (ferr_cnt - f0 != 2) begin bad++; $display("FAIL op11_err got=%0d exp=2", ferr_cnt - f0); end
    total++; if (evt_cnt != e0) begin bad++; $display("FAIL err_no_evt got=%0d exp=0", evt_cnt - e0); end
    loc_read(5'd7);
    total++; if (loc_rdata !== 16'hA5C3) begin bad++; $display("FAIL err_reg_kept got=%h exp=a5c3", loc_rdata); end
    do_read(32, PA, 5'd7);
    total++; if (rd_data !== 16'hA5C3 || oe_hits != 17) begin bad++; $display("FAIL err_recover got=%h/%0d exp=a5c3/17", rd_data, oe_hits); end
  endtask

  task automatic test_preamble;
    e0 = evt_cnt;
    do_write(31, 2'b01, PA, 5'd10, 2'b10, 16'h0F0E);
    total++; if (evt_cnt != e0) begin bad++; $display("FAIL pre31_ignored got=%0d exp=0", evt_cnt - e0); end
    loc_read(5'd10);
    total++; if (loc_rdata !== 16'h0000) begin bad++; $display("FAIL pre31_reg got=%h exp=0000", loc_rdata); end
    do_write(32, 2'b01, PA, 5'd10, 2'b10, 16'h0F0E);
    total++; if (evt_cnt - e0 != 1) begin bad++; $display("FAIL pre32_evt got=%0d exp=1", evt_cnt - e0); end
    total++; if (evt_data_s !== 16'h0F0E) begin bad++; $display("FAIL pre32_data got=%h exp=0f0e", evt_data_s); end
  endtask

  task automatic test_back_to_back;
    e0 = evt_cnt;
    do_write(32, 2'b01, PA, 5'd12, 2'b10, 16'h1111);
    do_write(32, 2'b01, PA, 5'd13, 2'b10, 16'h2222);
    total++; if (evt_cnt - e0 != 2) begin bad++; $display("FAIL b2b_evt got=%0d exp=2", evt_cnt - e0); end
    total++; if (evt_addr_s !== 5'd13) begin bad++; $display("FAIL b2b_addr got=%h exp=0d", evt_addr_s); end
    loc_read(5'd12);
    total++; if (loc_rdata !== 16'h1111) begin bad++; $display("FAIL b2b_reg12 got=%h exp=1111", loc_rdata); end
    loc_read(5'd13);
    total++; if (loc_rdata !== 16'h2222) begin bad++; $display("FAIL b2b_reg13 got=%h exp=2222", loc_rdata); end
    total++; if (both_cnt != 0) begin bad++; $display("FAIL evt_err_overlap got=%0d exp=0", both_cnt); end
  endtask

  task automatic test_reset_midframe;
    e0 = evt_cnt;
    header(32, 2'b10, PA, 5'd3);
    bit_cyc(1'b0, 1'b0);
    bit_cyc(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) bit_cyc(1'b0, 1'b0);
    repeat (5) @(negedge clk);
    total++; if (mdio_oe !== 1'b1) begin bad++; $display("FAIL mid_driving got=%b exp=1", mdio_oe); end
    resetn = 1'b0;
    #1;
    total++; if (mdio_oe !== 1'b0) begin bad++; $display("FAIL mid_async_oe got=%b exp=0", mdio_oe); end
    repeat (3) @(negedge clk);
    m_oe = 1'b0;
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    do_read(0, PA, 5'd3);
    total++; if (oe_hits != 0) begin bad++; $display("FAIL mid_need_preamble got=%0d exp=0", oe_hits); end
    do_read(32, PA, 5'd3);
    total++; if (rd_data !== ID2 || oe_hits != 17) begin bad++; $display("FAIL mid_recover got=%h/%0d exp=%h/17", rd_data, oe_hits, ID2); end
    total++; if (evt_cnt != e0) begin bad++; $display("FAIL mid_no_commit got=%0d exp=0", evt_cnt - e0); end
  endtask

  initial begin
    test_reset;
    test_read_id;
    test_write;
    test_local;
    test_bad_phyad;
    test_frame_err;
    test_preamble;
    test_back_to_back;
    test_reset_midframe;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
